cache_axi_arbiter: RTL and testbench
====================================

Name: cache_axi_arbiter

Overview:
- Shares the single cache-line AXI bridge between the I-cache (line reads only) and the D-cache (line reads and line write-backs).
- Selects one requester and latches its address, type and write line.
- Drives the bridge's hold-request/completion-pulse protocol, then returns a one-cycle grant and the read line to the winner.
- Sits between both caches and the AXI line bridge in the myCPU_cache top level.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line; LINE_WORDS = 1<<LINE_ADDR_LEN.
- ADDR_LEN, 32, address width of all address ports.

Ports:
- aclk  in  1  clock; the block has one clock.
- aresetn  in  1  reset; asynchronous and active-low.
- i_rd_req  in  1  I-cache line read request; held until i_gnt.
- i_addr  in  ADDR_LEN  I-cache line address.
- i_gnt  out  1  one-cycle completion pulse to the I-cache.
- i_rd_line  out  32 x LINE_WORDS  read line for the I-cache.
- d_rd_req  in  1  D-cache line read request.
- d_wr_req  in  1  D-cache line write request.
- d_addr  in  ADDR_LEN  D-cache line address.
- d_wr_line  in  32 x LINE_WORDS  D-cache write-back data.
- d_gnt  out  1  one-cycle completion pulse to the D-cache.
- d_rd_line  out  32 x LINE_WORDS  read line for the D-cache.
- m_gnt  in  1  bridge completion pulse.
- m_addr  out  ADDR_LEN  latched address to the bridge.
- m_rd_req  out  1  read request to the bridge.
- m_wr_req  out  1  write request to the bridge.
- m_wr_line  out  32 x LINE_WORDS  latched write line to the bridge.
- m_rd_line  in  32 x LINE_WORDS  bridge read line.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- States are IDLE, ISSUE and RESP. State, owner, type, address, write line and read-line buffer are all cleared asynchronously by aresetn low.
- Reset values: all outputs 0, state IDLE.
- Reset mid-transfer returns to IDLE immediately and drops the bridge request. The bridge shares aresetn, so no recovery sequence is needed.
- IDLE:
  - Requests are sampled only in IDLE.
  - If any request is high, pick the winner by the priority rule and latch owner, type, address and write line.
  - The latched address is forced line-aligned: bits [LINE_ADDR_LEN+1:0] = 0.
  - Go to ISSUE next cycle. Request-to-bridge latency is 1 cycle.
- Type rule: if d_wr_req and d_rd_req are both high, the type is WRITE. An I-cache transaction is always READ.
- ISSUE:
  - m_rd_req or m_wr_req (per latched type) is driven combinationally from the state and held high.
  - m_addr and m_wr_line stay stable from the latched registers for the whole transfer.
  - When m_gnt = 1: capture m_rd_line into the buffer (read type only) and go to RESP.
- RESP:
  - m_rd_req and m_wr_req are 0. This is mandatory: the bridge restarts if its request is still high in its IDLE cycle.
  - The owner's gnt is 1 for exactly one cycle. Next state is IDLE.
- i_rd_line and d_rd_line both present the shared buffer. The value is valid when the gnt is high and holds until the next read capture.
- Requester contract: deassert the request in the cycle after gnt. A request still high in the following IDLE cycle is treated as a new request.
- Priority (default, fixed): D-cache wins over I-cache.
- Minimum spacing between two back-to-back bridge transactions is 2 idle bridge cycles (RESP, IDLE).
- m_gnt outside ISSUE is ignored.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: a last-winner register, reset to I-cache. On contention in IDLE, the requester that did not win last gets the grant. A sole requester always wins and updates the last-winner register.
- Undefined: fixed D-over-I priority and no last-winner register.

Decomposition:
- Package cache_axi_pkg holds:
  - LINE_WORDS derivation;
  - typedef line_t (32 x LINE_WORDS array);
  - enum arb_state_e {IDLE, ISSUE, RESP};
  - enum req_type_e {RD, WR};
  - enum owner_e {OWN_I, OWN_D}.
- No sub-module: the selection logic is small and stays inline. The bridge remains a separate instance at the top level.

Test Plan:
- I-cache read alone: i_rd_req with i_addr = 0x1FC0_0004 -> m_addr = 0x1FC0_0000 and m_rd_req = 1 one cycle later. Bridge pulses m_gnt with line words 0..7 = 0xA0..0xA7 -> i_gnt high next cycle, i_rd_line matches, m_rd_req = 0 in that cycle, d_gnt stays 0.
- D-cache write-back: d_wr_req with d_addr = 0x8000_0020 and line 0x11..0x18 -> m_wr_req = 1, m_wr_line equal to that line and stable until m_gnt, then d_gnt pulses once.
- Contention, fixed priority: both caches request in the same cycle -> D-cache is served first, then I-cache in the IDLE after the D RESP. Exactly 2 bridge transactions, each gnt pulsed once.
- Contention with ARB_ROUND_ROBIN_EN, three consecutive contended rounds -> grant order I, D, I.
- Simultaneous d_rd_req and d_wr_req -> only m_wr_req asserted.
- Reset asserted in ISSUE while m_rd_req = 1 -> all outputs 0 immediately and busy = 0. After release, a new request is served normally.

Source files
------------

// File: rtl/cache_axi_pkg.sv
// ---------------------------------------------------------------------------
// cache_axi_pkg
// Shared types and constants for the cache-to-AXI line arbiter.
//   - line_words_f : number of 32-bit words per line for a given log2 size
//   - line_t       : default-size cache line (LINE_WORDS_DEF x 32 bits)
//   - arb_state_e  : arbiter FSM states
//   - req_type_e   : latched transaction type
//   - owner_e      : which cache owns the current transaction
// ---------------------------------------------------------------------------
package cache_axi_pkg;

    localparam int unsigned LINE_ADDR_LEN_DEF = 32'd3;
    localparam int unsigned LINE_WORDS_DEF    = 32'd1 << LINE_ADDR_LEN_DEF;

    // Words per line derived from log2(words per line).
    function automatic int unsigned line_words_f(input int unsigned line_addr_len);
        return 32'd1 << line_addr_len;
    endfunction

    typedef logic [LINE_WORDS_DEF-1:0][31:0] line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_e;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } req_type_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter
// Shares one cache-line AXI bridge between the I-cache (line reads) and the
// D-cache (line reads and write-backs). A request is sampled in IDLE, the
// winner's address/type/write line are latched, the bridge request is held
// in ISSUE until m_gnt, and RESP returns a one-cycle grant to the winner.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   i_rd_req, i_addr         I-cache line read request / address
//   i_gnt, i_rd_line         I-cache completion pulse / read line
//   d_rd_req, d_wr_req       D-cache line read / write-back requests
//   d_addr, d_wr_line        D-cache line address / write-back data
//   d_gnt, d_rd_line         D-cache completion pulse / read line
//   m_gnt, m_rd_line         bridge completion pulse / read line
//   m_addr, m_rd_req,
//   m_wr_req, m_wr_line      bridge request signals (latched)
//   busy                     high whenever the FSM is not IDLE
//
// Build option: ARB_ROUND_ROBIN_EN
//   defined   - contended requests alternate using a last-winner register
//   undefined - fixed priority, D-cache over I-cache
// ---------------------------------------------------------------------------
module cache_axi_arbiter
    import cache_axi_pkg::*;
#(
    parameter int unsigned  LINE_ADDR_LEN = LINE_ADDR_LEN_DEF,
    parameter int unsigned  ADDR_LEN      = 32'd32,
    localparam int unsigned LINE_WORDS    = line_words_f(LINE_ADDR_LEN)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic                           i_rd_req,
    input  logic [ADDR_LEN-1:0]            i_addr,
    output logic                           i_gnt,
    output logic [LINE_WORDS-1:0][31:0]    i_rd_line,
    input  logic                           d_rd_req,
    input  logic                           d_wr_req,
    input  logic [ADDR_LEN-1:0]            d_addr,
    input  logic [LINE_WORDS-1:0][31:0]    d_wr_line,
    output logic                           d_gnt,
    output logic [LINE_WORDS-1:0][31:0]    d_rd_line,
    input  logic                           m_gnt,
    output logic [ADDR_LEN-1:0]            m_addr,
    output logic                           m_rd_req,
    output logic                           m_wr_req,
    output logic [LINE_WORDS-1:0][31:0]    m_wr_line,
    input  logic [LINE_WORDS-1:0][31:0]    m_rd_line,
    output logic                           busy
);

    // Clears the byte-in-line and word-in-line address bits.
    localparam logic [ADDR_LEN-1:0] ALIGN_MASK =
        ~ADDR_LEN'((64'd1 << (LINE_ADDR_LEN + 32'd2)) - 64'd1);

    arb_state_e                   state_q, state_d;
    owner_e                       owner_q, owner_d;
    req_type_e                    type_q,  type_d;
    logic [ADDR_LEN-1:0]          addr_q,  addr_d;
    logic [LINE_WORDS-1:0][31:0]  wline_q, wline_d;
    logic [LINE_WORDS-1:0][31:0]  rbuf_q,  rbuf_d;

    owner_e                       win_s;
    logic                         d_req_s;
    logic                         any_req_s;

`ifdef ARB_ROUND_ROBIN_EN
    owner_e                       last_q;

    // Last-winner register: updated whenever a request is accepted in IDLE.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_q <= OWN_I;
        end else if ((state_q == IDLE) && any_req_s) begin
            last_q <= win_s;
        end else begin
            last_q <= last_q;
        end
    end
`endif

    // Winner selection among the currently raised requests.
    always_comb begin
        d_req_s   = d_rd_req | d_wr_req;
        any_req_s = d_req_s | i_rd_req;
        win_s     = OWN_I;
        if (d_req_s && i_rd_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            // The requester that did not win last time gets this one.
            win_s = (last_q == OWN_D) ? OWN_I : OWN_D;
`else
            win_s = OWN_D;
`endif
        end else if (d_req_s) begin
            win_s = OWN_D;
        end else begin
            win_s = OWN_I;
        end
    end

    // Next-state and latch logic for the transfer FSM.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rbuf_d  = rbuf_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    owner_d = win_s;
                    if (win_s == OWN_D) begin
                        // A write wins when both D-cache requests are raised.
                        type_d  = d_wr_req ? WR : RD;
                        addr_d  = d_addr & ALIGN_MASK;
                        wline_d = d_wr_line;
                    end else begin
                        type_d  = RD;
                        addr_d  = i_addr & ALIGN_MASK;
                        wline_d = '0;
                    end
                    state_d = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (m_gnt) begin
                    if (type_q == RD) begin
                        rbuf_d = m_rd_line;
                    end else begin
                        rbuf_d = rbuf_q;
                    end
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Transaction state registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            owner_q <= OWN_I;
            type_q  <= RD;
            addr_q  <= '0;
            wline_q <= '0;
            rbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            type_q  <= type_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rbuf_q  <= rbuf_d;
        end
    end

    // Bridge requests exist only in ISSUE so they are low in RESP, which
    // keeps the bridge from restarting on a stale request.
    assign m_rd_req  = (state_q == ISSUE) && (type_q == RD);
    assign m_wr_req  = (state_q == ISSUE) && (type_q == WR);
    assign m_addr    = addr_q;
    assign m_wr_line = wline_q;

    assign i_gnt     = (state_q == RESP) && (owner_q == OWN_I);
    assign d_gnt     = (state_q == RESP) && (owner_q == OWN_D);
    assign i_rd_line = rbuf_q;
    assign d_rd_line = rbuf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_axi_arbiter
// Directed bench for cache_axi_arbiter. Inputs are driven and outputs are
// sampled on the falling clock edge. Build option ARB_ROUND_ROBIN_EN selects
// the alternating contention order in the expected values.
// ---------------------------------------------------------------------------
module tb_cache_axi_arbiter;

    typedef logic [7:0][31:0] tline_t;

    logic        aclk;
    logic        aresetn;
    logic        i_rd_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    tline_t      i_rd_line;
    logic        d_rd_req;
    logic        d_wr_req;
    logic [31:0] d_addr;
    tline_t      d_wr_line;
    logic        d_gnt;
    tline_t      d_rd_line;
    logic        m_gnt;
    logic [31:0] m_addr;
    logic        m_rd_req;
    logic        m_wr_req;
    tline_t      m_wr_line;
    tline_t      m_rd_line;
    logic        busy;

    int vectors;
    int errors;
    int n_igt;
    int n_dgt;
    int n_issue;
    logic   req_prev;
    tline_t exp_buf;

    cache_axi_arbiter #(.LINE_ADDR_LEN(3), .ADDR_LEN(32)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .i_rd_req  (i_rd_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rd_line (i_rd_line),
        .d_rd_req  (d_rd_req),
        .d_wr_req  (d_wr_req),
        .d_addr    (d_addr),
        .d_wr_line (d_wr_line),
        .d_gnt     (d_gnt),
        .d_rd_line (d_rd_line),
        .m_gnt     (m_gnt),
        .m_addr    (m_addr),
        .m_rd_req  (m_rd_req),
        .m_wr_req  (m_wr_req),
        .m_wr_line (m_wr_line),
        .m_rd_line (m_rd_line),
        .busy      (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Counts grant pulses and bridge transaction starts.
    always @(posedge aclk) begin
        if (i_gnt) n_igt <= n_igt + 1;
        if (d_gnt) n_dgt <= n_dgt + 1;
        if ((m_rd_req | m_wr_req) && !req_prev) n_issue <= n_issue + 1;
        req_prev <= m_rd_req | m_wr_req;
    end

    // Hard stop in case the directed sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic tline_t mk_line(input logic [31:0] base);
        tline_t l;
        for (int k = 0; k < 8; k++) l[k] = base + 32'(k);
        return l;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on the falling edge in which the winner's request is visible to
    // the next rising edge; walks ISSUE and RESP and checks both.
    task automatic serve(input string tag, input bit own_d, input bit is_wr,
                         input logic [31:0] exp_addr, input tline_t wline,
                         input tline_t rline, input bit drop_all);
        @(negedge aclk);
        chk({tag, "_busy"},   256'(busy), 256'(1'b1));
        chk({tag, "_maddr"},  256'(m_addr), 256'(exp_addr));
        chk({tag, "_mrd"},    256'(m_rd_req), 256'(!is_wr));
        chk({tag, "_mwr"},    256'(m_wr_req), 256'(is_wr));
        if (is_wr) chk({tag, "_mwline"}, 256'(m_wr_line), 256'(wline));
        m_rd_line = rline;
        m_gnt     = 1'b1;
        @(negedge aclk);
        m_gnt = 1'b0;
        chk({tag, "_igt"},    256'(i_gnt), 256'(!own_d));
        chk({tag, "_dgt"},    256'(d_gnt), 256'(own_d));
        chk({tag, "_resp_mreq"}, 256'(m_rd_req | m_wr_req), 256'(1'b0));
        if (!is_wr) exp_buf = rline;
        chk({tag, "_irline"}, 256'(i_rd_line), 256'(exp_buf));
        chk({tag, "_drline"}, 256'(d_rd_line), 256'(exp_buf));
        if (own_d || drop_all) begin
            d_rd_req = 1'b0;
            d_wr_req = 1'b0;
        end
        if (!own_d || drop_all) i_rd_req = 1'b0;
        @(negedge aclk);
        chk({tag, "_idle_busy"}, 256'(busy), 256'(1'b0));
        chk({tag, "_idle_gnt"},  256'(i_gnt | d_gnt), 256'(1'b0));
    endtask

    initial begin
        int i0;
        int d0;
        int s0;
        bit first_d;
        vectors   = 0;
        errors    = 0;
        n_igt     = 0;
        n_dgt     = 0;
        n_issue   = 0;
        req_prev  = 1'b0;
        exp_buf   = '0;
        aresetn   = 1'b0;
        i_rd_req  = 1'b0;
        i_addr    = '0;
        d_rd_req  = 1'b0;
        d_wr_req  = 1'b0;
        d_addr    = '0;
        d_wr_line = '0;
        m_gnt     = 1'b0;
        m_rd_line = '0;

        // Reset state.
        #12;
        chk("rst_busy",  256'(busy), 256'(1'b0));
        chk("rst_mreq",  256'(m_rd_req | m_wr_req), 256'(1'b0));
        chk("rst_gnt",   256'(i_gnt | d_gnt), 256'(1'b0));
        chk("rst_maddr", 256'(m_addr), 256'(32'h0));
        chk("rst_rline", 256'(i_rd_line), 256'(0));
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        // I-cache read alone, unaligned address.
        i_rd_req = 1'b1;
        i_addr   = 32'h1FC0_0004;
        serve("iread", 1'b0, 1'b0, 32'h1FC0_0000, '0, mk_line(32'hA0), 1'b0);

        // D-cache write-back; write line must stay latched while waiting.
        d_wr_req  = 1'b1;
        d_addr    = 32'h8000_0020;
        d_wr_line = mk_line(32'h11);
        @(negedge aclk);
        chk("dwr_mwr",   256'(m_wr_req), 256'(1'b1));
        chk("dwr_mrd",   256'(m_rd_req), 256'(1'b0));
        chk("dwr_maddr", 256'(m_addr), 256'(32'h8000_0020));
        d_wr_line = mk_line(32'h77);
        serve("dwr", 1'b1, 1'b1, 32'h8000_0020, mk_line(32'h11), mk_line(32'hC0), 1'b0);

        // Contention: both caches request in the same cycle.
        i0 = n_igt; d0 = n_dgt; s0 = n_issue;
`ifdef ARB_ROUND_ROBIN_EN
        first_d = 1'b0;
`else
        first_d = 1'b1;
`endif
        i_rd_req = 1'b1;
        i_addr   = 32'h0000_1234;
        d_rd_req = 1'b1;
        d_addr   = 32'h0000_5678;
        if (first_d) begin
            serve("cont1", 1'b1, 1'b0, 32'h0000_5660, '0, mk_line(32'hB0), 1'b0);
            serve("cont2", 1'b0, 1'b0, 32'h0000_1220, '0, mk_line(32'hD0), 1'b0);
        end else begin
            serve("cont1", 1'b0, 1'b0, 32'h0000_1220, '0, mk_line(32'hB0), 1'b0);
            serve("cont2", 1'b1, 1'b0, 32'h0000_5660, '0, mk_line(32'hD0), 1'b0);
        end
        chk("cont_issues", 256'(n_issue - s0), 256'(2));
        chk("cont_igt",    256'(n_igt - i0),   256'(1));
        chk("cont_dgt",    256'(n_dgt - d0),   256'(1));

`ifdef ARB_ROUND_ROBIN_EN
        // Three contended rounds, loser withdraws each round: order I, D, I.
        for (int r = 0; r < 3; r++) begin
            i_rd_req = 1'b1;
            d_rd_req = 1'b1;
            serve("rr", (r == 1), 1'b0, (r == 1) ? 32'h0000_5660 : 32'h0000_1220,
                  '0, mk_line(32'h300 + 32'(r * 16)), 1'b1);
        end
`endif

        // Simultaneous D read and write: only the write is issued.
        d_rd_req  = 1'b1;
        d_wr_req  = 1'b1;
        d_addr    = 32'h0000_0100;
        d_wr_line = mk_line(32'h21);
        serve("drw", 1'b1, 1'b1, 32'h0000_0100, mk_line(32'h21), mk_line(32'hEE), 1'b0);

        // Stray bridge grant while idle is ignored.
        m_gnt     = 1'b1;
        m_rd_line = mk_line(32'hE0);
        @(negedge aclk);
        m_gnt = 1'b0;
        chk("stray_busy",  256'(busy), 256'(1'b0));
        chk("stray_gnt",   256'(i_gnt | d_gnt), 256'(1'b0));
        chk("stray_rline", 256'(i_rd_line), 256'(exp_buf));

        // Reset while a read is in ISSUE.
        i_rd_req = 1'b1;
        i_addr   = 32'h0000_0040;
        @(negedge aclk);
        chk("rmid_mrd", 256'(m_rd_req), 256'(1'b1));
        aresetn = 1'b0;
        #1;
        chk("rmid_mrd0",  256'(m_rd_req | m_wr_req), 256'(1'b0));
        chk("rmid_busy",  256'(busy), 256'(1'b0));
        chk("rmid_maddr", 256'(m_addr), 256'(32'h0));
        chk("rmid_rline", 256'(i_rd_line), 256'(0));
        i_rd_req = 1'b0;
        exp_buf  = '0;
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        i_rd_req = 1'b1;
        i_addr   = 32'h2000_0044;
        serve("post_rst", 1'b0, 1'b0, 32'h2000_0040, '0, mk_line(32'hF0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
